// File: rtl/pio_irq_master_pkg.sv
// Shared FSM state encoding and PIO register map for the PIO interrupt service master.
package pio_irq_master_pkg;

    typedef enum logic [2:0] {
        StInitMask,
        StIdle,
        StRdCap,
        StCapWait,
        StClrCap,
        StRdData,
        StDataWait,
        StReport
    } state_e;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

endpackage

// File: rtl/pio_rd_latency_tracker.sv
// Delays the read-accept strobe by the fixed slave read latency to mark the readdata sample cycle.
module pio_rd_latency_tracker #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic accept_i,
    output logic sample_o
);

    localparam logic [READ_LATENCY-1:0] One = 1;

    logic [READ_LATENCY-1:0] shift_q, shift_d;

    always_comb begin
        shift_d = (shift_q << 1) | (accept_i ? One : '0);
    end

    // Reset flushes in-flight strobes so data of an abandoned read is never sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign sample_o = shift_q[READ_LATENCY-1];

endmodule

// File: rtl/pio_irq_master.sv
// Avalon-MM master that services a PIO edge-capture interrupt: read, clear, read data, report.
module pio_irq_master
    import pio_irq_master_pkg::*;
#(
    parameter logic [31:0] MASK_INIT    = 32'h1,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned SVC_IDLE_GAP = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        irq,
    input  logic        enable,
    output logic        event_valid,
    output logic [31:0] event_capture,
    output logic [31:0] event_level,
    output logic [15:0] event_count,
    output logic [7:0]  spurious_count,
    output logic        busy
);

    localparam logic [15:0] GapTarget = 16'(SVC_IDLE_GAP);

    state_e      state_q, state_d;
    logic [15:0] gap_q, gap_d;
    logic        irq_q;
    logic [31:0] cap_q, cap_d;
    logic [31:0] ev_cap_q, ev_cap_d;
    logic [31:0] ev_lvl_q, ev_lvl_d;
    logic [15:0] ev_cnt_q, ev_cnt_d;
    logic [7:0]  sp_cnt_q, sp_cnt_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [1:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        accept, sample;

    assign accept = (rd_q | wr_q) & ~avm_waitrequest;

    pio_rd_latency_tracker #(
        .READ_LATENCY(READ_LATENCY)
    ) u_tracker (
        .clk      (clk),
        .reset_n  (reset_n),
        .accept_i (rd_q & ~avm_waitrequest),
        .sample_o (sample)
    );

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        ev_cap_d = ev_cap_q;
        ev_lvl_d = ev_lvl_q;
        ev_cnt_d = ev_cnt_q;
        sp_cnt_d = sp_cnt_q;
        gap_d    = '0;
        if (state_q == StIdle) begin
            gap_d = (gap_q < GapTarget) ? gap_q + 16'd1 : gap_q;
        end
        unique case (state_q)
            StInitMask: if (accept) state_d = StIdle;
            StIdle:     if (irq_q && enable && gap_q >= GapTarget) state_d = StRdCap;
            StRdCap:    if (accept) state_d = StCapWait;
            StCapWait: begin
                if (sample) begin
                    cap_d   = avm_readdata;
                    state_d = StClrCap;
                end
            end
            StClrCap: begin
                if (accept) begin
                    if (cap_q != '0) begin
                        state_d = StRdData;
                    end else begin
                        sp_cnt_d = (sp_cnt_q == 8'hFF) ? sp_cnt_q : sp_cnt_q + 8'd1;
                        state_d  = StIdle;
                    end
                end
            end
            StRdData:   if (accept) state_d = StDataWait;
            StDataWait: begin
                // Outputs update on REPORT entry so they are valid alongside the pulse.
                if (sample) begin
                    ev_cap_d = cap_q;
                    ev_lvl_d = avm_readdata;
                    ev_cnt_d = (ev_cnt_q == 16'hFFFF) ? ev_cnt_q : ev_cnt_q + 16'd1;
                    state_d  = StReport;
                end
            end
            StReport:   state_d = StIdle;
            default:    state_d = StInitMask;
        endcase
    end

    // Bus command registered from the next state so it is held for the whole state.
    always_comb begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = REG_DATA;
        wdata_d = '0;
        unique case (state_d)
            StInitMask: begin
                wr_d    = 1'b1;
                addr_d  = REG_MASK;
                wdata_d = MASK_INIT;
            end
            StRdCap: begin
                rd_d   = 1'b1;
                addr_d = REG_EDGE;
            end
            StClrCap: begin
                wr_d   = 1'b1;
                addr_d = REG_EDGE;
            end
            StRdData:   rd_d = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StInitMask;
            gap_q    <= '0;
            irq_q    <= 1'b0;
            cap_q    <= '0;
            ev_cap_q <= '0;
            ev_lvl_q <= '0;
            ev_cnt_q <= '0;
            sp_cnt_q <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            irq_q    <= irq;
            cap_q    <= cap_d;
            ev_cap_q <= ev_cap_d;
            ev_lvl_q <= ev_lvl_d;
            ev_cnt_q <= ev_cnt_d;
            sp_cnt_q <= sp_cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign event_valid    = (state_q == StReport);
    assign event_capture  = ev_cap_q;
    assign event_level    = ev_lvl_q;
    assign event_count    = ev_cnt_q;
    assign spurious_count = sp_cnt_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: doc/pio_irq_master.md
PIO_IRQ_MASTER -- requirements
Module: pio_irq_master

Interface
REQ-001 SHALL have parameter MASK_INIT, default 32'h1, the value written to the PIO interrupt-mask register after reset.
REQ-002 SHALL have parameter READ_LATENCY, default 1, the fixed slave read latency in cycles (range 1-4).
REQ-003 SHALL have parameter SVC_IDLE_GAP, default 2, the minimum number of IDLE cycles between two service sequences.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port avm_address, output, 2, the PIO register index (0 data, 2 irq mask, 3 edge capture).
REQ-007 SHALL have port avm_read, output, 1, the read command.
REQ-008 SHALL have port avm_write, output, 1, the write command.
REQ-009 SHALL have port avm_writedata, output, 32, the write data.
REQ-010 SHALL have port avm_readdata, input, 32, the slave read data.
REQ-011 SHALL have port avm_waitrequest, input, 1, the slave stall; tie 0 for no-wait slaves.
REQ-012 SHALL have port irq, input, 1, the PIO interrupt (level).
REQ-013 SHALL have port enable, input, 1, which allows new service sequences.
REQ-014 SHALL have port event_valid, output, 1, a one-cycle pulse marking a serviced edge event.
REQ-015 SHALL have port event_capture, output, 32, the edge-capture value read.
REQ-016 SHALL have port event_level, output, 32, the data-register value read after the clear.
REQ-017 SHALL have port event_count, output, 16, the number of valid events, saturating.
REQ-018 SHALL have port spurious_count, output, 8, the number of zero-capture services, saturating.
REQ-019 SHALL have port busy, output, 1, which is high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement the FSM states INIT_MASK, IDLE, RD_CAP, CAP_WAIT, CLR_CAP, RD_DATA, DATA_WAIT and REPORT.
REQ-021 SHALL perform one bus command per state, issued in that state and held stable (address, read/write, writedata) until a cycle with avm_waitrequest=0; that cycle is the accept cycle.
REQ-022 SHALL never assert avm_read and avm_write together and SHALL keep both low in the wait and IDLE states.
REQ-023 INIT_MASK: write MASK_INIT to address 2; on accept go to IDLE.
REQ-024 IDLE: go to RD_CAP when irq=1, enable=1 and the gap counter has reached SVC_IDLE_GAP; the gap counter restarts from 0 on each IDLE entry.
REQ-025 RD_CAP: read address 3; on accept go to CAP_WAIT.
REQ-026 CAP_WAIT: sample avm_readdata exactly READ_LATENCY cycles after the accept cycle into the capture register, then go to CLR_CAP.
REQ-027 CLR_CAP: write 32'h0 to address 3; on accept go to RD_DATA if the capture was nonzero, otherwise increment spurious_count and go to IDLE.
REQ-028 RD_DATA / DATA_WAIT: read address 0 and sample it READ_LATENCY cycles after accept into event_level.
REQ-029 REPORT: one cycle in which event_valid=1, event_capture holds and event_count increments; then go to IDLE.
REQ-030 event_capture and event_level SHALL hold their values until the next REPORT.
REQ-031 event_count SHALL saturate at 16'hFFFF and spurious_count SHALL saturate at 8'hFF, never wrapping.
REQ-032 An irq that asserts during a sequence SHALL NOT be queued; because irq is a level, it is re-serviced from IDLE if still high.
REQ-033 enable=0 mid-sequence SHALL NOT abort the sequence; it only blocks the next IDLE->RD_CAP transition.
REQ-034 Unbounded waitrequest SHALL stall the FSM indefinitely with the command held and no timeout.
REQ-035 No-stall latency: irq rising in IDLE (gap satisfied, READ_LATENCY=1) SHALL produce event_valid 7 cycles later.

Reset
REQ-036 On reset_n=0 (asynchronous) the FSM SHALL enter INIT_MASK with all avm outputs 0, event_valid 0, event_capture/event_level 0, both counters 0, busy 1 and the gap counter 0.
REQ-037 A reset mid-operation SHALL abandon any outstanding read and discard its data; the first command after release SHALL be the INIT_MASK write.

Structure
REQ-038 A shared package SHALL hold the FSM state enum and the PIO register index constants (REG_DATA=0, REG_MASK=2, REG_EDGE=3).
REQ-039 A sub-module pio_rd_latency_tracker SHALL handle the READ_LATENCY shift of the accept strobe and produce the sample strobe.

Verification
REQ-040 Reset release, waitrequest=0 -> first command is a write of 32'h1 to address 2; busy falls the cycle after.
REQ-041 irq high, capture=32'h1, data=32'h0 -> sequence rd3, wr3(0), rd0; event_valid pulse with capture 1, level 0, event_count 1.
REQ-042 waitrequest held 5 cycles on each command -> commands stable throughout, event delayed exactly 15 cycles, data correct.
REQ-043 capture reads 32'h0 -> write clear is issued, no event_valid, spurious_count=1.
REQ-044 Force event_count=16'hFFFE and service 3 events -> ends at 16'hFFFF with 3 event_valid pulses.
REQ-045 Reset asserted during CAP_WAIT with READ_LATENCY=3 -> late readdata ignored and the INIT_MASK write reissued after release.
